// File: rtl/combat_resolver.sv
`default_nettype none
// ============================================================================
// Module   : combat_resolver
// Purpose  : Per-frame combat handshake with battle_front; owns unit/tower HP
//            and reports kills and game over.
// Revision : 1.0 - initial release
// ============================================================================
module combat_resolver #(
    parameter logic [7:0] UNIT_HP  = 8'd40,
    parameter logic [7:0] TOWER_HP = 8'd200,
    parameter logic [7:0] DAMAGE   = 8'd5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frameTick,
    output logic       Start,
    input  logic       Done,
    output logic       Ack,
    input  logic [8:0] friendlyFront,
    input  logic [8:0] enemyFront,
    input  logic [4:0] unitDamageSelect,
    input  logic [4:0] enemyDamageSelect,
    input  logic       spawnUnit,
    input  logic       spawnEnemy,
    input  logic [3:0] spawnIdx,
    output logic       unitKilled,
    output logic       enemyKilled,
    output logic [4:0] unitKilledIdx,
    output logic [4:0] enemyKilledIdx,
    output logic [7:0] friendlyTowerHP,
    output logic [7:0] enemyTowerHP,
    input  logic       hpReadSide,
    input  logic [3:0] hpReadIdx,
    output logic [7:0] hpReadData,
    output logic       gameOver,
    output logic       playerWon,
    output logic       busy,
    output logic       frameOverrun
);

    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_REQ   = 5'b00010,
        S_WAIT  = 5'b00100,
        S_ACK   = 5'b01000,
        S_APPLY = 5'b10000
    } state_t;

    state_t     r_state;
    state_t     w_next;

    logic [8:0] r_friendly_front;
    logic [8:0] r_enemy_front;
    logic [4:0] r_unit_sel;
    logic [4:0] r_enemy_sel;

    logic [7:0] r_unit_hp  [16];
    logic [7:0] r_enemy_hp [16];
    logic [7:0] r_friendly_tower;
    logic [7:0] r_enemy_tower;

    logic       r_unit_killed;
    logic       r_enemy_killed;
    logic [4:0] r_unit_killed_idx;
    logic [4:0] r_enemy_killed_idx;
    logic       r_game_over;
    logic       r_player_won;
    logic       r_frame_overrun;

    logic       w_apply;
    logic       w_u_valid;
    logic       w_e_valid;
    logic [7:0] w_u_old;
    logic [7:0] w_e_old;
    logic [7:0] w_u_new;
    logic [7:0] w_e_new;
    logic       w_u_spawn_hit;
    logic       w_e_spawn_hit;
    logic       w_u_kill;
    logic       w_e_kill;
    logic [7:0] w_ft_next;
    logic [7:0] w_et_next;

    function automatic logic [7:0] sat_sub(input logic [7:0] hp);
        return (hp > DAMAGE) ? (hp - DAMAGE) : 8'd0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (frameTick && !r_game_over) w_next = S_REQ;
            S_REQ:   w_next = S_WAIT;
            S_WAIT:  if (Done) w_next = S_ACK;
            S_ACK:   w_next = S_APPLY;
            S_APPLY: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_friendly_front <= 9'd0;
            r_enemy_front    <= 9'd0;
            r_unit_sel       <= 5'd0;
            r_enemy_sel      <= 5'd0;
        end else if (r_state == S_WAIT && Done) begin
            r_friendly_front <= friendlyFront;
            r_enemy_front    <= enemyFront;
            r_unit_sel       <= unitDamageSelect;
            r_enemy_sel      <= enemyDamageSelect;
        end
    end

    // Bit 4 of a select means tower; only 16 itself is a valid tower address.
    always_comb begin
        w_apply       = (r_state == S_APPLY) && (r_friendly_front <= r_enemy_front);
        w_u_valid     = (r_unit_sel <= 5'd16);
        w_e_valid     = (r_enemy_sel <= 5'd16);
        w_u_old       = r_unit_sel[4]  ? r_friendly_tower : r_unit_hp[r_unit_sel[3:0]];
        w_e_old       = r_enemy_sel[4] ? r_enemy_tower    : r_enemy_hp[r_enemy_sel[3:0]];
        w_u_new       = sat_sub(w_u_old);
        w_e_new       = sat_sub(w_e_old);
        w_u_spawn_hit = spawnUnit  && !r_unit_sel[4]  && (spawnIdx == r_unit_sel[3:0]);
        w_e_spawn_hit = spawnEnemy && !r_enemy_sel[4] && (spawnIdx == r_enemy_sel[3:0]);
        w_u_kill      = w_apply && w_u_valid && (w_u_old != 8'd0) && (w_u_new == 8'd0) && !w_u_spawn_hit;
        w_e_kill      = w_apply && w_e_valid && (w_e_old != 8'd0) && (w_e_new == 8'd0) && !w_e_spawn_hit;
        w_ft_next     = (w_apply && r_unit_sel  == 5'd16) ? w_u_new : r_friendly_tower;
        w_et_next     = (w_apply && r_enemy_sel == 5'd16) ? w_e_new : r_enemy_tower;
    end

    // Spawn writes come last so they override damage to the same slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                r_unit_hp[i]  <= 8'd0;
                r_enemy_hp[i] <= 8'd0;
            end
            r_friendly_tower <= TOWER_HP;
            r_enemy_tower    <= TOWER_HP;
        end else begin
            if (w_apply && !r_unit_sel[4])  r_unit_hp[r_unit_sel[3:0]]   <= w_u_new;
            if (w_apply && !r_enemy_sel[4]) r_enemy_hp[r_enemy_sel[3:0]] <= w_e_new;
            if (spawnUnit)  r_unit_hp[spawnIdx]  <= UNIT_HP;
            if (spawnEnemy) r_enemy_hp[spawnIdx] <= UNIT_HP;
            r_friendly_tower <= w_ft_next;
            r_enemy_tower    <= w_et_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_unit_killed      <= 1'b0;
            r_enemy_killed     <= 1'b0;
            r_unit_killed_idx  <= 5'd0;
            r_enemy_killed_idx <= 5'd0;
            r_game_over        <= 1'b0;
            r_player_won       <= 1'b0;
            r_frame_overrun    <= 1'b0;
        end else begin
            r_unit_killed   <= w_u_kill;
            r_enemy_killed  <= w_e_kill;
            r_frame_overrun <= frameTick && (r_state != S_IDLE);
            if (w_u_kill) r_unit_killed_idx  <= r_unit_sel;
            if (w_e_kill) r_enemy_killed_idx <= r_enemy_sel;
            if (!r_game_over && (w_ft_next == 8'd0 || w_et_next == 8'd0)) begin
                r_game_over  <= 1'b1;
                r_player_won <= (w_et_next == 8'd0) && (w_ft_next != 8'd0);
            end
        end
    end

    assign Start           = (r_state == S_REQ);
    assign Ack             = (r_state == S_ACK);
    assign busy            = (r_state != S_IDLE);
    assign unitKilled      = r_unit_killed;
    assign enemyKilled     = r_enemy_killed;
    assign unitKilledIdx   = r_unit_killed_idx;
    assign enemyKilledIdx  = r_enemy_killed_idx;
    assign friendlyTowerHP = r_friendly_tower;
    assign enemyTowerHP    = r_enemy_tower;
    assign gameOver        = r_game_over;
    assign playerWon       = r_player_won;
    assign frameOverrun    = r_frame_overrun;
    assign hpReadData      = hpReadSide ? r_enemy_hp[hpReadIdx] : r_unit_hp[hpReadIdx];

endmodule
`default_nettype wire

// File: tb/tb_combat_resolver.sv
`default_nettype none
// ============================================================================
// Module   : tb_combat_resolver
// Purpose  : Directed table plus randomized frames against an HP-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_combat_resolver;
    localparam int UHP = 40;
    localparam int THP = 200;
    localparam int DMG = 5;

    logic       clk = 1'b0;
    logic       rst, frameTick, Done, Start, Ack;
    logic [8:0] friendlyFront, enemyFront;
    logic [4:0] unitDamageSelect, enemyDamageSelect;
    logic       spawnUnit, spawnEnemy;
    logic [3:0] spawnIdx;
    logic       unitKilled, enemyKilled;
    logic [4:0] unitKilledIdx, enemyKilledIdx;
    logic [7:0] friendlyTowerHP, enemyTowerHP;
    logic       hpReadSide;
    logic [3:0] hpReadIdx;
    logic [7:0] hpReadData;
    logic       gameOver, playerWon, busy, frameOverrun;

    always #5 clk = ~clk;

    combat_resolver dut (
        .clk(clk), .rst(rst), .frameTick(frameTick), .Start(Start), .Done(Done), .Ack(Ack),
        .friendlyFront(friendlyFront), .enemyFront(enemyFront),
        .unitDamageSelect(unitDamageSelect), .enemyDamageSelect(enemyDamageSelect),
        .spawnUnit(spawnUnit), .spawnEnemy(spawnEnemy), .spawnIdx(spawnIdx),
        .unitKilled(unitKilled), .enemyKilled(enemyKilled),
        .unitKilledIdx(unitKilledIdx), .enemyKilledIdx(enemyKilledIdx),
        .friendlyTowerHP(friendlyTowerHP), .enemyTowerHP(enemyTowerHP),
        .hpReadSide(hpReadSide), .hpReadIdx(hpReadIdx), .hpReadData(hpReadData),
        .gameOver(gameOver), .playerWon(playerWon), .busy(busy), .frameOverrun(frameOverrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain HP arrays updated by the game rules
    int m_unit [16];
    int m_enemy[16];
    int m_ft, m_et, m_uk_idx, m_ek_idx;
    bit m_go, m_pw, m_uk, m_ek;

    typedef struct {
        int ff; int ef; int us; int es; int rd;
        int exp_u; int exp_e; int uk; int ek;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_unit[i]  = 0;
            m_enemy[i] = 0;
        end
        m_ft = THP; m_et = THP; m_uk_idx = 0; m_ek_idx = 0;
        m_go = 0; m_pw = 0; m_uk = 0; m_ek = 0;
    endtask

    function automatic int sat(input int v);
        return (v > DMG) ? v - DMG : 0;
    endfunction

    task automatic model_apply(input int ff, input int ef, input int us, input int es,
                               input bit su, input bit se, input int sidx);
        int old;
        m_uk = 0; m_ek = 0;
        if (ff <= ef) begin
            if (us < 16) begin
                old = m_unit[us]; m_unit[us] = sat(old);
                if (old > 0 && m_unit[us] == 0 && !(su && sidx == us)) begin m_uk = 1; m_uk_idx = us; end
            end else if (us == 16) begin
                old = m_ft; m_ft = sat(old);
                if (old > 0 && m_ft == 0) begin m_uk = 1; m_uk_idx = 16; end
            end
            if (es < 16) begin
                old = m_enemy[es]; m_enemy[es] = sat(old);
                if (old > 0 && m_enemy[es] == 0 && !(se && sidx == es)) begin m_ek = 1; m_ek_idx = es; end
            end else if (es == 16) begin
                old = m_et; m_et = sat(old);
                if (old > 0 && m_et == 0) begin m_ek = 1; m_ek_idx = 16; end
            end
        end
        if (su) m_unit[sidx]  = UHP;
        if (se) m_enemy[sidx] = UHP;
        if (!m_go && (m_ft == 0 || m_et == 0)) begin
            m_go = 1;
            m_pw = (m_et == 0) && (m_ft != 0);
        end
    endtask

    task automatic read_hp(input bit side, input int idx, output int v);
        hpReadSide = side;
        hpReadIdx  = 4'(idx);
        #1 v = int'(hpReadData);
    endtask

    task automatic check_slot(input bit side, input int idx);
        int v;
        read_hp(side, idx, v);
        chk(side ? "enemy_hp" : "unit_hp", v, side ? m_enemy[idx] : m_unit[idx]);
    endtask

    task automatic check_status();
        chk("friendly_tower", int'(friendlyTowerHP), m_ft);
        chk("enemy_tower", int'(enemyTowerHP), m_et);
        chk("game_over", int'(gameOver), int'(m_go));
        chk("player_won", int'(playerWon), int'(m_pw));
        chk("unit_kill_idx", int'(unitKilledIdx), m_uk_idx);
        chk("enemy_kill_idx", int'(enemyKilledIdx), m_ek_idx);
    endtask

    task automatic sweep();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check_slot(1'b0, i);
            check_slot(1'b1, i);
        end
    endtask

    task automatic spawn(input bit su, input bit se, input int idx);
        @(negedge clk);
        spawnUnit = su; spawnEnemy = se; spawnIdx = 4'(idx);
        @(negedge clk);
        spawnUnit = 0; spawnEnemy = 0;
        if (su) m_unit[idx]  = UHP;
        if (se) m_enemy[idx] = UHP;
    endtask

    task automatic frame(input int ff, input int ef, input int us, input int es, input int waits,
                         input bit ovr, input bit su, input bit se, input int sidx,
                         output bit uk_s, output bit ek_s);
        @(negedge clk) frameTick = 1;
        @(negedge clk) frameTick = 0;
        chk("start_high", int'(Start), 1);
        chk("busy_high", int'(busy), 1);
        @(negedge clk) chk("start_one_cycle", int'(Start), 0);
        if (ovr) begin
            frameTick = 1;
            @(negedge clk) frameTick = 0;
            chk("overrun_pulse", int'(frameOverrun), 1);
            @(negedge clk) chk("overrun_clear", int'(frameOverrun), 0);
        end
        repeat (waits) @(negedge clk);
        chk("ack_before_done", int'(Ack), 0);
        friendlyFront = 9'(ff); enemyFront = 9'(ef);
        unitDamageSelect = 5'(us); enemyDamageSelect = 5'(es);
        Done = 1;
        @(negedge clk) chk("ack_high", int'(Ack), 1);
        Done = 0;
        friendlyFront = 9'($urandom_range(0, 511)); enemyFront = 9'($urandom_range(0, 511));
        unitDamageSelect = 5'($urandom_range(0, 31)); enemyDamageSelect = 5'($urandom_range(0, 31));
        @(negedge clk) chk("ack_one_cycle", int'(Ack), 0);
        spawnUnit = su; spawnEnemy = se; spawnIdx = 4'(sidx);
        model_apply(ff, ef, us, es, su, se, sidx);
        @(negedge clk);
        spawnUnit = 0; spawnEnemy = 0;
        uk_s = unitKilled; ek_s = enemyKilled;
        chk("unit_kill", int'(unitKilled), int'(m_uk));
        chk("enemy_kill", int'(enemyKilled), int'(m_ek));
        chk("busy_low", int'(busy), 0);
        check_status();
        check_slot(1'b0, us % 16);
        check_slot(1'b1, es % 16);
        if (su || se) begin
            check_slot(1'b0, sidx);
            check_slot(1'b1, sidx);
        end
        @(negedge clk);
        chk("unit_kill_clear", int'(unitKilled), 0);
        chk("enemy_kill_clear", int'(enemyKilled), 0);
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1;
        @(negedge clk);
        @(negedge clk) rst = 0;
        model_reset();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[7];
        bit uk, ek;
        int v;

        tbl[0] = '{100, 120,  3,  3, 3, 35, 35, 0, 0};
        tbl[1] = '{130, 120,  3,  3, 3, 35, 35, 0, 0};
        tbl[2] = '{120, 120,  3,  3, 3, 30, 30, 0, 0};
        tbl[3] = '{  0, 511, 20, 31, 3, 30, 30, 0, 0};
        tbl[4] = '{511,   0,  3,  3, 3, 30, 30, 0, 0};
        tbl[5] = '{ 10,  20,  4,  4, 4,  0,  0, 0, 0};
        tbl[6] = '{ 10,  20, 16, 16, 3, 30, 30, 0, 0};

        rst = 1; frameTick = 0; Done = 0; friendlyFront = 0; enemyFront = 0;
        unitDamageSelect = 0; enemyDamageSelect = 0; spawnUnit = 0; spawnEnemy = 0;
        spawnIdx = 0; hpReadSide = 0; hpReadIdx = 0;
        do_reset();

        chk("reset_busy", int'(busy), 0);
        chk("reset_start", int'(Start), 0);
        chk("reset_ack", int'(Ack), 0);
        chk("reset_overrun", int'(frameOverrun), 0);
        chk("reset_unit_kill", int'(unitKilled), 0);
        chk("reset_enemy_kill", int'(enemyKilled), 0);
        check_status();
        sweep();

        spawn(1, 1, 3);
        foreach (tbl[i]) begin
            frame(tbl[i].ff, tbl[i].ef, tbl[i].us, tbl[i].es, 0, 0, 0, 0, 0, uk, ek);
            read_hp(1'b0, tbl[i].rd, v); chk("tbl_unit_hp", v, tbl[i].exp_u);
            read_hp(1'b1, tbl[i].rd, v); chk("tbl_enemy_hp", v, tbl[i].exp_e);
            chk("tbl_unit_kill", int'(uk), tbl[i].uk);
            chk("tbl_enemy_kill", int'(ek), tbl[i].ek);
        end
        chk("tbl_friendly_tower", int'(friendlyTowerHP), 195);
        chk("tbl_enemy_tower", int'(enemyTowerHP), 195);

        // Drain slot 5 on both sides to a kill, then hit the empty slot again
        spawn(1, 1, 5);
        repeat (7) frame(100, 100, 5, 5, 1, 0, 0, 0, 0, uk, ek);
        frame(100, 100, 5, 5, 0, 0, 0, 0, 0, uk, ek);
        chk("kill5_unit", int'(uk), 1);
        chk("kill5_enemy", int'(ek), 1);
        chk("kill5_unit_idx", int'(unitKilledIdx), 5);
        frame(100, 100, 5, 5, 0, 0, 0, 0, 0, uk, ek);
        chk("empty5_no_kill", int'(uk), 0);

        // Spawn in the killing APPLY cycle wins, with an overrun frameTick
        spawn(1, 1, 5);
        repeat (7) frame(50, 60, 5, 5, 0, 0, 0, 0, 0, uk, ek);
        frame(50, 60, 5, 5, 2, 1, 1, 1, 5, uk, ek);
        chk("spawn_wins_no_kill", int'(uk), 0);
        read_hp(1'b0, 5, v);
        chk("spawn_wins_hp", v, 40);

        for (int n = 0; n < 60; n++) begin
            int us, es;
            bit su, se;
            if ($urandom_range(0, 3) == 0) spawn($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                                                 $urandom_range(0, 15));
            us = $urandom_range(0, 30);
            if (us >= 16) us++;
            es = $urandom_range(0, 31);
            su = ($urandom_range(0, 3) == 0);
            se = ($urandom_range(0, 3) == 0);
            frame($urandom_range(0, 511), $urandom_range(0, 511), us, es, $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0, su, se, $urandom_range(0, 15), uk, ek);
        end
        sweep();

        for (int n = 0; n < 45 && !m_go; n++) frame(10, 20, 17, 16, 0, 0, 0, 0, 0, uk, ek);
        chk("win_game_over", int'(gameOver), 1);
        chk("win_player_won", int'(playerWon), 1);
        chk("win_enemy_kill_idx", int'(enemyKilledIdx), 16);
        @(negedge clk) frameTick = 1;
        @(negedge clk) frameTick = 0;
        chk("gameover_no_start", int'(Start), 0);
        @(negedge clk) chk("gameover_idle", int'(busy), 0);

        // Reset in WAIT with Done pending: no Ack afterwards
        do_reset();
        @(negedge clk) frameTick = 1;
        @(negedge clk) frameTick = 0;
        @(negedge clk) Done = 1;
        rst = 1;
        @(negedge clk) rst = 0;
        chk("rst_wait_busy", int'(busy), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_wait_no_ack", int'(Ack), 0);
            chk("rst_wait_no_start", int'(Start), 0);
        end
        Done = 0;
        chk("rst_game_over", int'(gameOver), 0);
        chk("rst_player_won", int'(playerWon), 0);

        for (int n = 0; n < 45 && !m_go; n++) frame(0, 0, 16, 16, 0, 0, 0, 0, 0, uk, ek);
        chk("draw_game_over", int'(gameOver), 1);
        chk("draw_player_won", int'(playerWon), 0);
        chk("draw_friendly_tower", int'(friendlyTowerHP), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
